// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Brief    : RV32IM writeback stage; arbitrates the register-file write port
//            between the pipeline and a FIFO-buffered mul/div unit.
//            Optional macro WB_FWD_EN adds combinational fwd_* bypass outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
  parameter int XLEN          = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int MD_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [1:0]            pipe_wb_sel,
  input  logic [XLEN-1:0]       pipe_alu_res,
  input  logic [XLEN-1:0]       pipe_load_data,
  input  logic [XLEN-1:0]       pipe_pc4,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_result,
  output logic                  md_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       write_data
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  localparam int PTR_W = $clog2(MD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MD_FIFO_DEPTH);

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [REG_ADDR_W-1:0] rd_mem_q   [MD_FIFO_DEPTH];
  logic [XLEN-1:0]       data_mem_q [MD_FIFO_DEPTH];

  logic                  pipe_take;
  logic                  md_acc;
  logic                  md_live;
  logic                  fifo_ne;
  logic                  push;
  logic                  pop;
  logic [XLEN-1:0]       pipe_data;

  assign md_ready = (count_q < DEPTH_C);

  always_comb begin
    pipe_take = pipe_valid && (pipe_rd != '0);
    md_acc    = md_valid && md_ready;
    // x0 results from mul/div are accepted but never queued or written.
    md_live   = md_acc && (md_rd != '0);
    fifo_ne   = (count_q != '0);

    case (pipe_wb_sel)
      2'b01:   pipe_data = pipe_load_data;
      2'b10:   pipe_data = pipe_pc4;
      default: pipe_data = pipe_alu_res;
    endcase

    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    write_data_d = write_data_q;
    push         = 1'b0;
    pop          = 1'b0;

    if (pipe_take) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = pipe_rd;
      write_data_d = pipe_data;
      push         = md_live;
    end else if (fifo_ne) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = rd_mem_q[rd_ptr_q];
      write_data_d = data_mem_q[rd_ptr_q];
      pop          = 1'b1;
      push         = md_live;
    end else if (md_live) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = md_rd;
      write_data_d = md_result;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      write_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      write_data_q <= write_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= md_rd;
      data_mem_q[wr_ptr_q] <= md_result;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign write_data = write_data_q;

`ifdef WB_FWD_EN
  assign fwd_valid = rst_n & wr_en_d;
  assign fwd_rd    = rst_n ? wr_addr_d : '0;
  assign fwd_data  = rst_n ? write_data_d : '0;
`endif

endmodule

`default_nettype wire
